// File: rtl/lockin_demod.sv
// Dual-phase lock-in demodulator: multiplies ADC samples by the DDS sin/cos references,
// integrates both products over a 2^n boxcar window and dumps the window averages as I/Q.
module lockin_demod #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_LOG2N = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [4:0]                 n_log2,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   adc_in,
  input  logic signed [DATA_W-1:0]   sin_in,
  input  logic signed [DATA_W-1:0]   cos_in,
  output logic signed [2*DATA_W-1:0] i_out,
  output logic signed [2*DATA_W-1:0] q_out,
  output logic                       out_valid
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned ACC_W  = 2 * DATA_W + MAX_LOG2N;
  localparam int unsigned CNT_W  = MAX_LOG2N + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INTEG = 2'd1,
    DUMP  = 2'd2
  } state_t;

  // S1: input capture
  logic                     v1;
  logic signed [DATA_W-1:0] adc1, sin1, cos1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      adc1 <= '0;
      sin1 <= '0;
      cos1 <= '0;
    end else begin
      v1   <= in_valid;
      adc1 <= adc_in;
      sin1 <= sin_in;
      cos1 <= cos_in;
    end
  end

  // S2: full-precision products
  logic                     p_valid;
  logic signed [PROD_W-1:0] prod_i, prod_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_valid <= 1'b0;
      prod_i  <= '0;
      prod_q  <= '0;
    end else begin
      p_valid <= v1;
      prod_i  <= PROD_W'(adc1) * PROD_W'(sin1);
      prod_q  <= PROD_W'(adc1) * PROD_W'(cos1);
    end
  end

  // S3: window accumulator and dump control
  state_t                   state, state_d;
  logic signed [ACC_W-1:0]  acc_i, acc_q, acc_i_d, acc_q_d;
  logic [CNT_W-1:0]         count, count_d;
  logic [4:0]               n_lat, n_lat_d;
  logic [4:0]               n_clamp_c;
  logic signed [PROD_W-1:0] i_d, q_d;
  logic                     ov_d;
  logic signed [ACC_W-1:0]  ext_i_c, ext_q_c;

  assign n_clamp_c = (n_log2 > 5'(MAX_LOG2N)) ? 5'(MAX_LOG2N) : n_log2;
  assign ext_i_c   = ACC_W'(prod_i);
  assign ext_q_c   = ACC_W'(prod_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc_i     <= '0;
      acc_q     <= '0;
      count     <= '0;
      n_lat     <= '0;
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      acc_i     <= acc_i_d;
      acc_q     <= acc_q_d;
      count     <= count_d;
      n_lat     <= n_lat_d;
      i_out     <= i_d;
      q_out     <= q_d;
      out_valid <= ov_d;
    end
  end

  always_comb begin
    state_d = state;
    acc_i_d = acc_i;
    acc_q_d = acc_q;
    count_d = count;
    n_lat_d = n_lat;
    i_d     = i_out;
    q_d     = q_out;
    ov_d    = 1'b0;
    case (state)
      IDLE: begin
        acc_i_d = '0;
        acc_q_d = '0;
        count_d = '0;
        if (en) begin
          state_d = INTEG;
          n_lat_d = n_clamp_c;
        end
      end
      INTEG: begin
        if (!en) begin
          state_d = IDLE;
          acc_i_d = '0;
          acc_q_d = '0;
          count_d = '0;
        end else if (p_valid) begin
          acc_i_d = acc_i + ext_i_c;
          acc_q_d = acc_q + ext_q_c;
          count_d = count + CNT_W'(1);
          if (count_d == (CNT_W'(1) << n_lat)) state_d = DUMP;
        end
      end
      DUMP: begin
        ov_d    = 1'b1;
        i_d     = PROD_W'(acc_i >>> n_lat);
        q_d     = PROD_W'(acc_q >>> n_lat);
        n_lat_d = n_clamp_c;
        if (!en) begin
          state_d = IDLE;
          acc_i_d = '0;
          acc_q_d = '0;
          count_d = '0;
        end else if (p_valid) begin
          // The sample arriving during the dump opens the next window; a 1-sample window dumps again.
          acc_i_d = ext_i_c;
          acc_q_d = ext_q_c;
          count_d = CNT_W'(1);
          state_d = (n_clamp_c == 5'd0) ? DUMP : INTEG;
        end else begin
          acc_i_d = '0;
          acc_q_d = '0;
          count_d = '0;
          state_d = INTEG;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
